// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles 4-byte UART command frames (HDR, ADDR, DATA, CHK) into register writes
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_data, rx_vld     byte stream from the UART receiver
//   reg_addr, reg_wdata last good write, held until the next good frame
//   reg_wr              one-cycle write strobe
//   frame_err           one-cycle error strobe
//   err_code            cause of the last error (01 checksum, 10 timeout), held
//   err_cnt             saturating error counter
//   busy                frame in progress
//   tx_busy             downstream transmitter busy (echo build only)
//   tx_data, tx_vld     ACK/NAK reply byte and strobe (echo build only)
//
// Build option: define UART_CMD_ECHO_EN to enable the ACK/NAK reply path;
// otherwise tx_data/tx_vld are tied to 0 and tx_busy is ignored.
module uart_cmd_ctrl #(
   parameter logic [7:0] HDR_BYTE = 8'hA5,
   parameter int         TIMEOUT  = 104160,
   parameter int         TO_W     = 17,
   parameter logic [7:0] ACK_BYTE = 8'h5A,
   parameter logic [7:0] NAK_BYTE = 8'hEE
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_vld,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic [7:0] err_cnt,
   output logic       busy,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_vld
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, CHK} state_t;
   state_t          state;
   logic [7:0]      addr_tmp, data_tmp, err_cnt_inc;
   logic [TO_W-1:0] to_cnt;
   logic            timeout, sum_ok;
   assign busy        = state != IDLE;
   // a byte arriving on the terminal count cycle keeps the frame alive
   assign timeout     = busy && !rx_vld && to_cnt == TO_W'(TIMEOUT - 1);
   assign sum_ok      = rx_data == 8'(addr_tmp + data_tmp);
   assign err_cnt_inc = err_cnt == 8'hFF ? err_cnt : err_cnt + 8'd1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_tmp  <= '0;
         data_tmp  <= '0;
         to_cnt    <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= '0;
         err_cnt   <= '0;
      end else begin
         reg_wr    <= 1'b0;
         frame_err <= 1'b0;
         to_cnt    <= (!busy || rx_vld || timeout) ? '0 : to_cnt + 1'b1;
         if (timeout) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            err_code  <= 2'b10;
            err_cnt   <= err_cnt_inc;
         end else if (rx_vld) begin
            case (state)
               IDLE: if (rx_data == HDR_BYTE) state <= ADDR;
               ADDR: begin
                  addr_tmp <= rx_data;
                  state    <= DATA;
               end
               DATA: begin
                  data_tmp <= rx_data;
                  state    <= CHK;
               end
               CHK: begin
                  state <= IDLE;
                  if (sum_ok) begin
                     reg_addr  <= addr_tmp;
                     reg_wdata <= data_tmp;
                     reg_wr    <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= 2'b01;
                     err_cnt   <= err_cnt_inc;
                  end
               end
            endcase
         end
      end
   end
`ifdef UART_CMD_ECHO_EN
   logic       reply_pend, chk_done;
   logic [7:0] reply_byte;
   assign chk_done = rx_vld && state == CHK;
   // a completion in the same cycle as a send re-arms the single reply slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reply_pend <= 1'b0;
         reply_byte <= '0;
         tx_data    <= '0;
         tx_vld     <= 1'b0;
      end else begin
         tx_vld <= reply_pend && !tx_busy;
         if (reply_pend && !tx_busy) begin
            tx_data    <= reply_byte;
            reply_pend <= 1'b0;
         end
         if (chk_done) begin
            reply_pend <= 1'b1;
            reply_byte <= sum_ok ? ACK_BYTE : NAK_BYTE;
         end
      end
   end
`else
   logic unused_echo;
   assign unused_echo = ^{tx_busy, ACK_BYTE, NAK_BYTE};
   assign tx_data     = '0;
   assign tx_vld      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
`ifdef UART_CMD_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif
   localparam int TO = 20;
   logic       clk = 1'b0, rst_n;
   logic [7:0] rx_data, reg_addr, reg_wdata, err_cnt, tx_data;
   logic       rx_vld, reg_wr, frame_err, busy, tx_busy, tx_vld;
   logic [1:0] err_code;
   int         n_tests = 0, n_fail = 0, bad;

   uart_cmd_ctrl #(.TIMEOUT(TO), .TO_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
      .frame_err(frame_err), .err_code(err_code), .err_cnt(err_cnt),
      .busy(busy), .tx_busy(tx_busy), .tx_data(tx_data), .tx_vld(tx_vld)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_vld  = 1'b1;
   endtask

   // returns on the negedge right after the CHK byte was sampled
   task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      send(a);
      send(b);
      send(c);
      send(d);
      @(negedge clk);
      rx_vld = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rx_vld = 1'b0; rx_data = '0; tx_busy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_reg_addr", reg_addr, 0);
      check("rst_reg_wdata", reg_wdata, 0);
      check("rst_reg_wr", reg_wr, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_tx", {tx_vld, tx_data}, 0);
      rst_n = 1'b1;

      // good frame, busy observed mid-frame
      send(8'hA5);
      send(8'h12);
      check("good_busy_mid", busy, 1);
      send(8'h34);
      send(8'h46);
      @(negedge clk);
      rx_vld = 1'b0;
      check("good_wr", reg_wr, 1);
      check("good_addr", reg_addr, 8'h12);
      check("good_wdata", reg_wdata, 8'h34);
      check("good_ferr", frame_err, 0);
      check("good_errcnt", err_cnt, 0);
      check("good_busy", busy, 0);
      @(negedge clk);
      check("good_wr_1cyc", reg_wr, 0);
      check("good_tx", {tx_vld, tx_data}, ECHO ? 9'h15A : 9'h0);

      // bad checksum
      frame(8'hA5, 8'h12, 8'h34, 8'h47);
      check("bad_ferr", frame_err, 1);
      check("bad_code", err_code, 2'b01);
      check("bad_cnt", err_cnt, 1);
      check("bad_wr", reg_wr, 0);
      check("bad_reg_hold", {reg_addr, reg_wdata}, 16'h1234);
      @(negedge clk);
      check("bad_ferr_1cyc", frame_err, 0);
      check("bad_tx", {tx_vld, tx_data}, ECHO ? 9'h1EE : 9'h0);

      // timeout after the address byte: error TO clocks after the last byte
      send(8'hA5);
      send(8'h12);
      @(negedge clk);
      rx_vld = 1'b0;
      repeat (TO - 1) @(negedge clk);
      check("to_early_ferr", frame_err, 0);
      check("to_early_busy", busy, 1);
      @(negedge clk);
      check("to_ferr", frame_err, 1);
      check("to_code", err_code, 2'b10);
      check("to_cnt", err_cnt, 2);
      check("to_busy", busy, 0);
      check("to_no_tx", tx_vld, 0);
      frame(8'hA5, 8'h01, 8'h02, 8'h03);
      check("to_after_wr", reg_wr, 1);
      check("to_after_regs", {reg_addr, reg_wdata}, 16'h0102);
      check("to_after_code", err_code, 2'b10);

      // byte on the terminal-count cycle keeps the frame alive
      send(8'hA5);
      send(8'h12);
      @(negedge clk);
      rx_vld = 1'b0;
      repeat (TO - 2) @(negedge clk);
      send(8'h34);
      @(negedge clk);
      rx_vld = 1'b0;
      check("tc_race_ferr", frame_err, 0);
      check("tc_race_busy", busy, 1);
      send(8'h46);
      @(negedge clk);
      rx_vld = 1'b0;
      check("tc_race_wr", reg_wr, 1);
      check("tc_race_regs", {reg_addr, reg_wdata}, 16'h1234);
      check("tc_race_cnt", err_cnt, 2);

      // leading garbage ignored, exactly one write
      send(8'h00);
      send(8'hFF);
      send(8'hA5);
      check("garb_idle", busy, 0);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      @(negedge clk);
      rx_vld = 1'b0;
      check("garb_wr", reg_wr, 1);
      check("garb_regs", {reg_addr, reg_wdata}, 16'h0000);
      @(negedge clk);
      check("garb_one_wr", reg_wr, 0);
      check("garb_cnt", err_cnt, 2);

      // header value used as an address
      frame(8'hA5, 8'hA5, 8'h01, 8'hA6);
      check("hdr_addr_wr", reg_wr, 1);
      check("hdr_addr_regs", {reg_addr, reg_wdata}, 16'hA501);

      // saturation: 300 bad frames on top of 2 errors
      for (int i = 0; i < 300; i++) frame(8'hA5, 8'h00, 8'h00, 8'h01);
      check("sat_ferr", frame_err, 1);
      check("sat_cnt", err_cnt, 8'hFF);
      check("sat_code", err_code, 2'b01);
      check("sat_regs", {reg_addr, reg_wdata}, 16'hA501);

`ifdef UART_CMD_ECHO_EN
      repeat (3) @(negedge clk);
      // reply held off by tx_busy
      tx_busy = 1'b1;
      frame(8'hA5, 8'h12, 8'h34, 8'h46);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx_vld) bad++;
      end
      check("echo_hold", bad, 0);
      tx_busy = 1'b0;
      @(negedge clk);
      check("echo_ack", {tx_vld, tx_data}, 9'h15A);
      @(negedge clk);
      check("echo_ack_1cyc", tx_vld, 0);
      // latest completion wins
      tx_busy = 1'b1;
      frame(8'hA5, 8'h12, 8'h34, 8'h46);
      frame(8'hA5, 8'h12, 8'h34, 8'h47);
      repeat (5) @(negedge clk);
      tx_busy = 1'b0;
      @(negedge clk);
      check("echo_nak", {tx_vld, tx_data}, 9'h1EE);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (tx_vld) bad++;
      end
      check("echo_single", bad, 0);
`endif

      // reset mid-frame discards the partial frame
      send(8'hA5);
      send(8'h12);
      @(negedge clk);
      rx_vld = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_cnt", err_cnt, 0);
      check("mrst_regs", {reg_addr, reg_wdata, err_code}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h34);
      send(8'h46);
      @(negedge clk);
      rx_vld = 1'b0;
      check("mrst_no_wr", {reg_wr, frame_err, busy}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
